// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A-B-BIN one bit per cycle, LSB first, and
// presents D/BOUT/ZERO with a one-cycle DONE pulse after WIDTH shift cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             br;
  logic             br_nxt;
  logic             diff;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             accept;

  function automatic logic diff_bit(input logic x, input logic y, input logic bw);
    return x ^ y ^ bw;
  endfunction

  function automatic logic borrow_bit(input logic x, input logic y, input logic bw);
    return (~x & y) | (~(x ^ y) & bw);
  endfunction

  assign diff    = diff_bit(a_sr[0], b_sr[0], br);
  assign br_nxt  = borrow_bit(a_sr[0], b_sr[0], br);
  assign res_nxt = {diff, res_sr[WIDTH-1:1]};
  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign accept  = start && (state != SHIFT);

  assign busy = (state == SHIFT);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = FIN;
      FIN:     state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, one bit per cycle in SHIFT, result latch on FIN entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      bout   <= 1'b0;
      zero   <= 1'b1;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      br     <= bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= res_nxt;
      br     <= br_nxt;
      cnt    <= cnt + 1'b1;
      if (last) begin
        d    <= res_nxt;
        bout <= br_nxt;
        zero <= (res_nxt == '0);
      end
    end
  end

endmodule
